// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks a wrapping range of sync_rom addresses and streams the words out through a 4-entry FIFO
// Ports: clk, rst (synchronous, active-high)
//        start, start_addr, count : burst command, sampled only while idle
//        busy, done               : burst in progress / one-cycle completion pulse
//        rom_addr, rom_dout       : registered address to, and read data from, a 1-cycle sync_rom
//        m_valid, m_ready, m_data, m_last : output stream, m_last on the final beat
module rom_burst_reader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [AW:0] one = 1;
    state_t state;
    logic [AW-1:0] next_addr;
    logic [AW:0] issue_left;
    logic issue_q, issue_last_q, rd_q, rd_last_q;
    logic [WIDTH:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;
    logic issue, push, pop;
    // A read is only issued when the FIFO has room for it plus every word still in the ROM pipeline.
    assign issue = state == RUN && issue_left != '0 &&
                   (4'(fifo_count) + 4'(issue_q) + 4'(rd_q) < 4'd4);
    assign push = rd_q;
    assign pop = m_valid && m_ready;
    assign m_valid = fifo_count != 3'd0;
    assign m_data = m_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
    assign m_last = m_valid && mem[rd_ptr][WIDTH];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {rd_last_q, rom_dout};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            rom_addr <= '0;
            next_addr <= '0;
            issue_left <= '0;
            issue_q <= 1'b0;
            issue_last_q <= 1'b0;
            rd_q <= 1'b0;
            rd_last_q <= 1'b0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            done <= 1'b0;
            rd_q <= issue_q;
            rd_last_q <= issue_last_q;
            issue_q <= 1'b0;
            issue_last_q <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(push) - 3'(pop);
            if (state == IDLE) begin
                // The first address goes out on the start edge itself, saving a cycle of latency.
                if (start && count != '0) begin
                    state <= RUN;
                    busy <= 1'b1;
                    rom_addr <= start_addr;
                    next_addr <= start_addr + 1'b1;
                    issue_left <= count - one;
                    issue_q <= 1'b1;
                    issue_last_q <= count == one;
                end else if (start) begin
                    done <= 1'b1;
                end
            end else begin
                if (issue) begin
                    rom_addr <= next_addr;
                    next_addr <= next_addr + 1'b1;
                    issue_left <= issue_left - one;
                    issue_q <= 1'b1;
                    issue_last_q <= issue_left == one;
                end
                if (pop && m_last) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk)
        if (!rst && push) assert (fifo_count < 3'd4);
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: scoreboard bench for rom_burst_reader driving a sync_rom model
module tb_rom_burst_reader;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, m_valid, m_ready, m_last;
    logic [2:0] start_addr = 3'd0, rom_addr;
    logic [3:0] count = 4'd0;
    logic [7:0] rom_dout, m_data;
    logic [7:0] rom [8];
    logic [8:0] q [$];
    logic [8:0] hold_w, e;
    logic [3:0] pat = 4'b1001;
    logic prev_stall = 1'b0, bp = 1'b0;
    int checks = 0, errors = 0, beats = 0, ph = 0, fmax = 0;
    int bn, va, vn, da, n, b0;

    rom_burst_reader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_dout <= rom[rom_addr];

    always @(posedge clk) begin
        #1;
        m_ready = bp ? pat[ph[1:0]] : 1'b1;
        ph = (ph + 1) % 4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int sa, input int len, input bit expect_beats);
        start_addr = 3'(sa);
        count = 4'(len);
        start = 1'b1;
        if (expect_beats)
            for (int i = 0; i < len; i++) q.push_back({i == len - 1, rom[(sa + i) % 8]});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 200);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_drained"}, 32'(q.size()), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) chk("hold", {m_valid, m_last, m_data}, {1'b1, hold_w});
            if (m_valid && m_ready) begin
                beats++;
                if (q.size() == 0) chk("extra_beat", 32'(q.size()), 1);
                else begin
                    e = q.pop_front();
                    chk("beat", {m_last, m_data}, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            hold_w = {m_last, m_data};
            if (int'(dut.fifo_count) > fmax) fmax = int'(dut.fifo_count);
        end else prev_stall = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d beats seen", beats);
        $fatal(1, "watchdog");
    end

    initial begin
        rom = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h12, 8'h34};
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        tick();
        rst = 1'b0;
        tick();

        burst(3, 1, 1);
        bn = 0; va = -1; vn = 0; da = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) bn++;
            if (m_valid) begin
                vn++;
                if (va < 0) va = i;
            end
            if (done && da < 0) da = i;
        end
        chk("single_busy_cycles", bn, 3);
        chk("single_valid_at", va, 2);
        chk("single_valid_cycles", vn, 1);
        chk("single_done_at", da, 3);
        chk("single_drained", q.size(), 0);
        tick();

        burst(6, 4, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) chk("wrap_addr", rom_addr, (6 + i) % 8);
            if (i >= 2) chk("wrap_valid", m_valid, 1);
        end
        wait_done("wrap");

        bp = 1'b1;
        burst(0, 8, 1);
        wait_done("sweep");
        bp = 1'b0;
        chk("fifo_max_le4", 32'(fmax <= 4), 1);

        count = 4'd0;
        start_addr = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_valid0", m_valid, 0);
        repeat (4) begin
            @(negedge clk);
            chk("zero_valid", m_valid, 0);
            chk("zero_busy", busy, 0);
        end
        tick();

        burst(0, 8, 1);
        repeat (2) tick();
        start_addr = 3'd2;
        count = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored");
        repeat (4) begin
            @(negedge clk);
            chk("ignored_quiet", m_valid | busy, 0);
        end
        tick();

        burst(0, 8, 1);
        b0 = beats;
        n = 0;
        while (beats < b0 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_three_beats", beats - b0, 3);
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_last", m_last, 0);
        chk("midrst_addr", rom_addr, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
            chk("midrst_no_valid", m_valid, 0);
        end
        tick();
        burst(5, 2, 1);
        wait_done("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
